// File: rtl/writeback_scoreboard.sv
// In-order writeback and scoreboard stage feeding decode's register-file write port.
// Tracks each issued destination, counts down its latency, retires results in issue
// order and raises a source-hazard stall against pending destinations.
// Optional feature: define SB_FWD_EN to add fwd_hit/fwd_data retire-cycle forwarding.
module writeback_scoreboard #(
  parameter int DEPTH = 8,
  parameter int W     = 32
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         issue_valid,
  output logic                         issue_ready,
  input  logic [1:0]                   issue_rw,
  input  logic [4:0]                   issue_rd,
  input  logic [4:0]                   issue_wait,
  input  logic [5:0]                   src_rs,
  input  logic [5:0]                   src_rt,
  output logic                         stall,
  input  logic                         res_valid,
  input  logic [W-1:0]                 res_data,
  output logic [1:0]                   wr_rw,
  output logic [4:0]                   wr_rd,
  output logic [W-1:0]                 wr_data,
  output logic [$clog2(DEPTH):0]       pending,
  output logic                         proto_err
`ifdef SB_FWD_EN
  ,
  output logic                         fwd_hit,
  output logic [W-1:0]                 fwd_data
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [1:0]       rw_q  [DEPTH];
  logic [4:0]       rd_q  [DEPTH];
  logic [4:0]       cnt_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [AW-1:0]    head_q;
  logic [AW-1:0]    tail_q;

  logic             full;
  logic             empty;
  logic [1:0]       issue_rw_m;
  logic             do_issue;
  logic             retire_p0;
  logic             bad_p0;
  logic [DEPTH-1:0] hit_rs;
  logic [DEPTH-1:0] hit_rt;
  logic [DEPTH-1:0] head_oh;

  // Class-aware match of one stored destination against a decode source.
  function automatic logic src_hit(input logic [1:0] rw, input logic [4:0] rd,
                                   input logic [5:0] src);
    return (rw != 2'b00) && (rw[1] == src[5]) && (rd == src[4:0]);
  endfunction

  assign full        = (pending == PW'(DEPTH));
  assign empty       = (pending == '0);
  assign issue_ready = ~full;
  // Class 11 is treated as "no destination" everywhere, so it is folded at entry.
  assign issue_rw_m  = (issue_rw == 2'b11) ? 2'b00 : issue_rw;
  assign do_issue    = issue_valid & ~full;
  assign retire_p0   = res_valid & ~empty & (cnt_q[head_q] == 5'd0);
  assign bad_p0      = (issue_valid & full) |
                       (res_valid & (empty | (cnt_q[head_q] != 5'd0)));

  // Per-entry hazard match vectors for both decode sources.
  always_comb begin
    hit_rs  = '0;
    hit_rt  = '0;
    head_oh = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit_rs[i]  = vld_q[i] & src_hit(rw_q[i], rd_q[i], src_rs);
      hit_rt[i]  = vld_q[i] & src_hit(rw_q[i], rd_q[i], src_rt);
      head_oh[i] = (AW'(i) == head_q);
    end
  end

`ifdef SB_FWD_EN
  logic fwd_rs;
  logic fwd_rt;

  // A source is forwarded only when the retiring head is its sole pending producer.
  always_comb begin
    fwd_rs   = retire_p0 & (rw_q[head_q] != 2'b00) & (hit_rs == head_oh);
    fwd_rt   = retire_p0 & (rw_q[head_q] != 2'b00) & (hit_rt == head_oh);
    fwd_hit  = fwd_rs | fwd_rt;
    fwd_data = fwd_hit ? res_data : '0;
    stall    = ((|hit_rs) & ~fwd_rs) | ((|hit_rt) & ~fwd_rt);
  end
`else
  // Without forwarding the head keeps stalling through its own retire cycle.
  always_comb begin
    stall = (|hit_rs) | (|hit_rt);
  end
`endif

  // Queue control, occupancy, sticky error and the registered write port.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head_q    <= '0;
      tail_q    <= '0;
      vld_q     <= '0;
      pending   <= '0;
      proto_err <= 1'b0;
      wr_rw     <= 2'b00;
      wr_rd     <= '0;
      wr_data   <= '0;
    end else begin
      if (do_issue) begin
        tail_q         <= tail_q + AW'(1);
        vld_q[tail_q]  <= 1'b1;
      end
      if (retire_p0) begin
        head_q         <= head_q + AW'(1);
        vld_q[head_q]  <= 1'b0;
      end
      case ({do_issue, retire_p0})
        2'b10:   pending <= pending + PW'(1);
        2'b01:   pending <= pending - PW'(1);
        default: pending <= pending;
      endcase
      if (bad_p0) proto_err <= 1'b1;
      wr_rw <= retire_p0 ? rw_q[head_q] : 2'b00;
      if (retire_p0) begin
        wr_rd   <= rd_q[head_q];
        wr_data <= res_data;
      end
    end
  end

  // Entry payload: write at tail, otherwise saturating latency countdown.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (do_issue && (tail_q == AW'(i))) begin
        rw_q[i]  <= issue_rw_m;
        rd_q[i]  <= issue_rd;
        cnt_q[i] <= issue_wait;
      end else if (cnt_q[i] != 5'd0) begin
        cnt_q[i] <= cnt_q[i] - 5'd1;
      end
    end
  end

endmodule

// File: tb/tb_writeback_scoreboard.sv
// Scoreboard bench for writeback_scoreboard; define SB_FWD_EN to cover forwarding.
module tb_writeback_scoreboard;
  localparam int DEPTH = 8;
  localparam int W     = 32;

  logic         clk = 1'b0;
  logic         rstn;
  logic         issue_valid;
  logic         issue_ready;
  logic [1:0]   issue_rw;
  logic [4:0]   issue_rd;
  logic [4:0]   issue_wait;
  logic [5:0]   src_rs;
  logic [5:0]   src_rt;
  logic         stall;
  logic         res_valid;
  logic [W-1:0] res_data;
  logic [1:0]   wr_rw;
  logic [4:0]   wr_rd;
  logic [W-1:0] wr_data;
  logic [3:0]   pending;
  logic         proto_err;
`ifdef SB_FWD_EN
  logic         fwd_hit;
  logic [W-1:0] fwd_data;
`endif

  writeback_scoreboard #(.DEPTH(DEPTH), .W(W)) dut (
    .clk(clk), .rstn(rstn),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_rw(issue_rw), .issue_rd(issue_rd), .issue_wait(issue_wait),
    .src_rs(src_rs), .src_rt(src_rt), .stall(stall),
    .res_valid(res_valid), .res_data(res_data),
    .wr_rw(wr_rw), .wr_rd(wr_rd), .wr_data(wr_data),
    .pending(pending), .proto_err(proto_err)
`ifdef SB_FWD_EN
    , .fwd_hit(fwd_hit), .fwd_data(fwd_data)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] rw;
    logic [4:0] rd;
    int         cnt;
  } ent_t;

  typedef struct {
    logic [4:0]   rd;
    logic [W-1:0] data;
  } wr_t;

  ent_t mq[$];
  wr_t  expq[$];
  int   total = 0;
  int   bad   = 0;
  logic m_err = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic m_match(input ent_t e, input logic [5:0] s);
    return (e.rw != 2'b00) && (e.rw[1] == s[5]) && (e.rd == s[4:0]);
  endfunction

  // One clock of stimulus; the model predicts stall before the edge and the
  // registered outputs after it.
  task automatic cyc(input logic iv, input logic [1:0] rw, input logic [4:0] rd,
                     input logic [4:0] wt, input logic rv, input logic [W-1:0] d);
    logic       ret, iss, hs, ht;
    logic [1:0] mrw;
    int         n_rs, n_rt;
    ent_t       e;
    wr_t        w;
    issue_valid = iv; issue_rw = rw; issue_rd = rd; issue_wait = wt;
    res_valid = rv; res_data = d;
    #1;
    ret = rv && (mq.size() > 0) && (mq[0].cnt == 0);
    iss = iv && (mq.size() < DEPTH);
    if ((iv && mq.size() >= DEPTH) || (rv && !ret)) m_err = 1'b1;
    n_rs = 0; n_rt = 0;
    foreach (mq[i]) begin
      if (m_match(mq[i], src_rs)) n_rs++;
      if (m_match(mq[i], src_rt)) n_rt++;
    end
    hs = (n_rs != 0);
    ht = (n_rt != 0);
`ifdef SB_FWD_EN
    begin
      logic fs, ft;
      fs = ret && (mq[0].rw != 2'b00) && (n_rs == 1) && m_match(mq[0], src_rs);
      ft = ret && (mq[0].rw != 2'b00) && (n_rt == 1) && m_match(mq[0], src_rt);
      check("fwd_hit", fwd_hit, fs | ft);
      check("fwd_data", fwd_data, (fs | ft) ? d : '0);
      hs = hs && !fs;
      ht = ht && !ft;
    end
`endif
    check("stall", stall, hs | ht);
    mrw = 2'b00;
    if (ret) begin
      mrw = mq[0].rw;
      w.rd = mq[0].rd; w.data = d;
      expq.push_back(w);
    end
    @(posedge clk); #1;
    if (ret) e = mq.pop_front();
    foreach (mq[i]) if (mq[i].cnt > 0) mq[i].cnt--;
    if (iss) begin
      e.rw = (rw == 2'b11) ? 2'b00 : rw;
      e.rd = rd;
      e.cnt = int'(wt);
      mq.push_back(e);
    end
    check("wr_rw", wr_rw, mrw);
    if (ret) begin
      w = expq.pop_front();
      check("wr_rd", wr_rd, w.rd);
      check("wr_data", wr_data, w.data);
    end
    check("pending", pending, mq.size());
    check("issue_ready", issue_ready, mq.size() < DEPTH);
    check("proto_err", proto_err, m_err);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 2'b00, 5'd0, 5'd0, 1'b0, '0);
  endtask

  task automatic do_reset();
    rstn = 1'b0; issue_valid = 1'b0; res_valid = 1'b0;
    #1;
    check("rst_pending", pending, 0);
    check("rst_ready", issue_ready, 1);
    check("rst_stall", stall, 0);
    check("rst_wr_rw", wr_rw, 0);
    check("rst_wr_rd", wr_rd, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_err", proto_err, 0);
`ifdef SB_FWD_EN
    check("rst_fwd_hit", fwd_hit, 0);
    check("rst_fwd_data", fwd_data, 0);
`endif
    mq.delete(); expq.delete(); m_err = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
  endtask

  initial begin
    int guard;
    rstn = 1'b1; issue_valid = 1'b0; issue_rw = 2'b00; issue_rd = '0; issue_wait = '0;
    res_valid = 1'b0; res_data = '0; src_rs = 6'h3e; src_rt = 6'h3e;
    #2;
    do_reset();

    // GPR r5, zero latency, retire next cycle.
    cyc(1'b1, 2'b01, 5'd5, 5'd0, 1'b0, '0);
    cyc(1'b0, 2'b00, 5'd0, 5'd0, 1'b1, 32'h1234);
    check("t1_rw", wr_rw, 2'b01);
    check("t1_rd", wr_rd, 5);
    check("t1_data", wr_data, 32'h1234);
    idle(1);
    check("t1_rw_drop", wr_rw, 2'b00);

    // FPR f3 with latency 5; early result is a protocol error.
    src_rs = 6'b100011;
    cyc(1'b1, 2'b10, 5'd3, 5'd5, 1'b0, '0);
    idle(1);
    cyc(1'b0, 2'b00, 5'd0, 5'd0, 1'b1, 32'hbad0);
    check("t2_err", proto_err, 1);
    check("t2_head_kept", pending, 1);
    guard = 0;
    while (mq.size() > 0 && mq[0].cnt != 0 && guard < 40) begin
      idle(1);
      check("t2_stall_wait", stall, 1);
      guard++;
    end
    check("t2_bound", guard < 40, 1);
    cyc(1'b0, 2'b00, 5'd0, 5'd0, 1'b1, 32'h0f0f_0003);
    check("t2_rw", wr_rw, 2'b10);
    idle(1);
    check("t2_stall_clear", stall, 0);

    // Fill, overflow, retire, retire+issue, drain.
    do_reset();
    src_rs = 6'h3e; src_rt = 6'h3e;
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 2'b01, 5'(i + 8), 5'd0, 1'b0, '0);
    check("t3_ready_full", issue_ready, 0);
    check("t3_pending_full", pending, 8);
    cyc(1'b1, 2'b01, 5'd20, 5'd0, 1'b0, '0);
    check("t3_err_full", proto_err, 1);
    cyc(1'b0, 2'b00, 5'd0, 5'd0, 1'b1, 32'h100);
    cyc(1'b1, 2'b01, 5'd21, 5'd0, 1'b1, 32'h101);
    check("t3_pending_same", pending, 7);
    cyc(1'b1, 2'b01, 5'd22, 5'd0, 1'b0, '0);
    cyc(1'b1, 2'b01, 5'd23, 5'd0, 1'b1, 32'h102);
    guard = 0;
    while (mq.size() > 0 && guard < 20) begin
      cyc(1'b0, 2'b00, 5'd0, 5'd0, 1'b1, $urandom);
      guard++;
    end
    check("t3_drained", pending, 0);

    // Class separation: GPR r7 vs FPR r7; class 11 never stalls.
    do_reset();
    src_rs = 6'h3e; src_rt = 6'b000111;
    cyc(1'b1, 2'b01, 5'd7, 5'd0, 1'b0, '0);
    cyc(1'b1, 2'b10, 5'd7, 5'd0, 1'b0, '0);
    cyc(1'b1, 2'b11, 5'd7, 5'd0, 1'b0, '0);
    check("t4_stall_gpr", stall, 1);
    cyc(1'b0, 2'b00, 5'd0, 5'd0, 1'b1, 32'h77);
    idle(1);
    check("t4_stall_fpr_only", stall, 0);
    cyc(1'b0, 2'b00, 5'd0, 5'd0, 1'b1, 32'h78);
    cyc(1'b0, 2'b00, 5'd0, 5'd0, 1'b1, 32'h79);
    check("t4_rw11_strobe", wr_rw, 2'b00);

    // Reset while two entries are in flight.
    cyc(1'b1, 2'b01, 5'd1, 5'd3, 1'b0, '0);
    cyc(1'b1, 2'b10, 5'd2, 5'd0, 1'b0, '0);
    do_reset();
    idle(6);
    check("t5_no_write", wr_rw, 2'b00);

`ifdef SB_FWD_EN
    // Sole producer retiring forwards; a second producer keeps the stall.
    do_reset();
    src_rs = 6'b000100; src_rt = 6'h3e;
    cyc(1'b1, 2'b01, 5'd4, 5'd0, 1'b0, '0);
    cyc(1'b0, 2'b00, 5'd0, 5'd0, 1'b1, 32'hdeadbeef);
    cyc(1'b1, 2'b01, 5'd4, 5'd0, 1'b0, '0);
    cyc(1'b1, 2'b01, 5'd4, 5'd0, 1'b0, '0);
    cyc(1'b0, 2'b00, 5'd0, 5'd0, 1'b1, 32'h1);
    cyc(1'b0, 2'b00, 5'd0, 5'd0, 1'b1, 32'h2);
`endif

    // Random traffic over a small register window.
    do_reset();
    for (int k = 0; k < 400; k++) begin
      src_rs = {1'($urandom_range(0, 1)), 3'b000, 2'($urandom_range(0, 3))};
      src_rt = {1'($urandom_range(0, 1)), 3'b000, 2'($urandom_range(0, 3))};
      cyc(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          5'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
